// File: rtl/sr_cmd_pkg.sv
// ----------------------------------------------------------------------------
// sr_cmd_pkg
//   Shared encodings for the SR-latch command sequencer.
//   - FSM state codes (IDLE, PULSE_SET, PULSE_RST, GAP)
//   - Command type codes used by the arbiter and the pending slot
//   - Helper mapping a command type to the pulse state that serves it
// ----------------------------------------------------------------------------
package sr_cmd_pkg;

  typedef logic [1:0] state_t;
  typedef logic [1:0] cmd_t;

  // FSM state encoding
  localparam state_t IDLE      = 2'd0;
  localparam state_t PULSE_SET = 2'd1;
  localparam state_t PULSE_RST = 2'd2;
  localparam state_t GAP       = 2'd3;

  // Command type encoding (also the pending-slot tag)
  localparam cmd_t CMD_NONE = 2'd0;
  localparam cmd_t CMD_SET  = 2'd1;
  localparam cmd_t CMD_RST  = 2'd2;

  // Pulse state that serves a given (non-empty) command.
  function automatic state_t pulse_state(input cmd_t cmd);
    return (cmd == CMD_RST) ? PULSE_RST : PULSE_SET;
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// ----------------------------------------------------------------------------
// sr_debounce
//   Two-flop synchroniser followed by a counting debouncer for one raw,
//   asynchronous request level.
//
//   Ports
//     clock    in  rising-edge clock
//     reset_n  in  asynchronous active-low reset (clears everything to 0)
//     din      in  raw asynchronous level
//     level    out debounced level (registered)
//     rise     out one-cycle pulse, high in the cycle after level went 0->1
//
//   Timing: the first edge that samples din high is edge 1; the debounced
//   level (and rise) go high after edge DEB_CYCLES+2 if din stays high.
// ----------------------------------------------------------------------------
module sr_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          rise_q,  rise_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = cnt_q;
    if (sync2_q != level_q) begin
      // The cycle that would bring the count to DEB_CYCLES accepts the new
      // level instead, so the counter never holds its terminal value and
      // cannot wrap.
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/sr_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// sr_cmd_sequencer
//   Command stage in front of an SR latch. Raw set/reset requests are
//   synchronised and debounced; each debounced rising edge is a command that
//   becomes one timed (s or r, control) pulse followed by an idle gap.
//   Simultaneous commands are arbitrated so s and r are never high together.
//
//   Ports
//     clock    in  rising-edge clock
//     reset_n  in  asynchronous active-low reset; all outputs drop at once
//     set_req  in  raw asynchronous set request (level)
//     rst_req  in  raw asynchronous reset request (level)
//     s        out latch set input        (registered)
//     r        out latch reset input      (registered)
//     control  out latch enable           (registered, high whenever s|r)
//     busy     out high in PULSE_* or GAP (registered)
//     conflict out one-cycle pulse when both commands arrive on one edge
//
//   Handshake: there is none; requests are levels and commands are edges.
//   A command arriving while busy is parked in a single pending slot (last
//   one wins) and served right after the following IDLE cycle.
// ----------------------------------------------------------------------------
module sr_cmd_sequencer
  import sr_cmd_pkg::*;
#(
  parameter int DEB_CYCLES   = 4,
  parameter int PULSE_CYCLES = 5,
  parameter int GAP_CYCLES   = 2,
  parameter int PRIORITY_RST = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic set_req,
  input  logic rst_req,
  output logic s,
  output logic r,
  output logic control,
  output logic busy,
  output logic conflict
);

  localparam int MAX_T = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW    = $clog2(MAX_T + 1);

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic set_level, set_rise;
  logic rst_level, rst_rise;

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (set_req),
    .level   (set_level),
    .rise    (set_rise)
  );

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rst (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (rst_req),
    .level   (rst_level),
    .rise    (rst_rise)
  );

  // --------------------------------------------------------------------------
  // Arbiter: at most one command type survives per edge
  // --------------------------------------------------------------------------
  logic both_cmd;
  cmd_t new_cmd;

  always_comb begin
    both_cmd = set_rise & rst_rise;
    new_cmd  = CMD_NONE;
    if (both_cmd) begin
      new_cmd = (PRIORITY_RST != 0) ? CMD_RST : CMD_SET;
    end else if (set_rise) begin
      new_cmd = CMD_SET;
    end else if (rst_rise) begin
      new_cmd = CMD_RST;
    end
  end

  // --------------------------------------------------------------------------
  // FSM, pending slot and shared pulse/gap counter
  // --------------------------------------------------------------------------
  state_t        state_q, state_d;
  cmd_t          pend_q,  pend_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // An older pending command is served first; a command arriving on
        // the same edge takes its place in the slot.
        if (pend_q != CMD_NONE) begin
          state_d = pulse_state(pend_q);
          pend_d  = new_cmd;
        end else if (new_cmd != CMD_NONE) begin
          state_d = pulse_state(new_cmd);
        end
      end
      PULSE_SET, PULSE_RST: begin
        if (new_cmd != CMD_NONE) begin
          pend_d = new_cmd;
        end
        if (cnt_q == CW'(PULSE_CYCLES - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (new_cmd != CMD_NONE) begin
          pend_d = new_cmd;
        end
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output registers: decoded from the next state so each output is a flop
  // that changes on the same edge as the state it reflects.
  // --------------------------------------------------------------------------
  logic s_q, s_d;
  logic r_q, r_d;
  logic control_q, control_d;
  logic busy_q, busy_d;
  logic conflict_q, conflict_d;

  always_comb begin
    s_d        = (state_d == PULSE_SET);
    r_d        = (state_d == PULSE_RST);
    control_d  = s_d | r_d;
    busy_d     = (state_d != IDLE);
    conflict_d = both_cmd;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pend_q     <= CMD_NONE;
      cnt_q      <= '0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      control_q  <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      s_q        <= s_d;
      r_q        <= r_d;
      control_q  <= control_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign control  = control_q;
  assign busy     = busy_q;
  assign conflict = conflict_q;

  // Latch-safety invariants.
  a_no_sr_both : assert property (@(posedge clock) disable iff (!reset_n) !(s_q && r_q));
  a_ctl_cover  : assert property (@(posedge clock) disable iff (!reset_n) (s_q || r_q) |-> control_q);

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_sr_cmd_sequencer
//   Directed scenarios followed by randomized request bursts. The reference
//   model works on absolute edge numbers: debounce is a sliding window over
//   the history of sampled request levels, and the sequencer is a schedule of
//   pulse start times with a one-entry pending slot.
// ----------------------------------------------------------------------------
module tb_sr_cmd_sequencer;

  localparam int DEB   = 4;
  localparam int PUL   = 5;
  localparam int GAP_C = 2;
  localparam int PRIO  = 1;
  localparam int MAXE  = 8192;

  // --------------------------------------------------------------------------
  // Clock / reset / DUT
  // --------------------------------------------------------------------------
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic set_req = 1'b0;
  logic rst_req = 1'b0;
  logic s, r, control, busy, conflict;

  always #5 clock = ~clock;

  sr_cmd_sequencer #(
    .DEB_CYCLES   (DEB),
    .PULSE_CYCLES (PUL),
    .GAP_CYCLES   (GAP_C),
    .PRIORITY_RST (PRIO)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .set_req  (set_req),
    .rst_req  (rst_req),
    .s        (s),
    .r        (r),
    .control  (control),
    .busy     (busy),
    .conflict (conflict)
  );

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  int n_total = 0;
  int n_bad   = 0;
  logic [4:0] exp_q[$];   // {s, r, control, busy, conflict} per edge

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  int e = 0;                  // number of rising edges so far
  bit hs[0:MAXE];             // set_req sampled at edge k (0 while in reset)
  bit hr[0:MAXE];
  bit lvl_s = 0, lvl_r = 0;   // debounced levels
  bit rs_prev = 0, rr_prev = 0; // debounced rises produced at edge e
  int cur = 0;                // 0 none, 1 set, 2 rst: most recent pulse
  int cur_start = 0;          // edge after which that pulse is visible
  int pend = 0;

  // Level flips at edge k when the samples k-DEB-1 .. k-2 all differ from it.
  function automatic bit win_flip(input int k, input bit use_rst, input bit lvl);
    bit v;
    for (int j = k - DEB - 1; j <= k - 2; j++) begin
      v = (j < 1) ? 1'b0 : (use_rst ? hr[j] : hs[j]);
      if (v == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge();
    logic [4:0] ex;
    int  nw;
    bit  conf, fs, fr, in_pulse, in_busy;
    e++;
    if (!reset_n) begin
      hs[e] = 1'b0; hr[e] = 1'b0;
      lvl_s = 0; lvl_r = 0; rs_prev = 0; rr_prev = 0;
      cur = 0; pend = 0;
      exp_q.push_back(5'b0);
      return;
    end
    hs[e] = set_req;
    hr[e] = rst_req;
    conf = rs_prev && rr_prev;
    nw   = conf ? ((PRIO != 0) ? 2 : 1) : (rs_prev ? 1 : (rr_prev ? 2 : 0));
    // Free to start when the previous schedule has reached its IDLE cycle.
    if (cur == 0 || (e - 1) >= cur_start + PUL + GAP_C) begin
      if (pend != 0) begin
        cur = pend; cur_start = e; pend = nw;
      end else if (nw != 0) begin
        cur = nw; cur_start = e;
      end
    end else if (nw != 0) begin
      pend = nw;
    end
    fs = win_flip(e, 1'b0, lvl_s);
    fr = win_flip(e, 1'b1, lvl_r);
    rs_prev = fs && !lvl_s;
    rr_prev = fr && !lvl_r;
    if (fs) lvl_s = !lvl_s;
    if (fr) lvl_r = !lvl_r;
    in_pulse = (cur != 0) && (e >= cur_start) && (e < cur_start + PUL);
    in_busy  = (cur != 0) && (e >= cur_start) && (e < cur_start + PUL + GAP_C);
    ex[4] = in_pulse && (cur == 1);
    ex[3] = in_pulse && (cur == 2);
    ex[2] = in_pulse;
    ex[1] = in_busy;
    ex[0] = conf;
    exp_q.push_back(ex);
  endtask

  // --------------------------------------------------------------------------
  // Driver
  // --------------------------------------------------------------------------
  bit q_lat = 0;              // behavioural SR latch fed by the DUT outputs
  int cnt_s, cnt_r, cnt_busy, cnt_conf;
  int last_s, first_r;

  task automatic clear_counts();
    cnt_s = 0; cnt_r = 0; cnt_busy = 0; cnt_conf = 0;
    last_s = -1; first_r = -1;
  endtask

  task automatic drive(input logic sv, input logic rv, input logic rn);
    logic [4:0] got;
    @(negedge clock);
    set_req = sv;
    rst_req = rv;
    if (!rn && reset_n) begin
      reset_n = 1'b0;
      #1;
      check("async_drop", {3'b0, s, r, control, busy, conflict}, 8'h00);
    end else begin
      reset_n = rn;
    end
    @(posedge clock);
    #1;
    model_edge();
    got = {s, r, control, busy, conflict};
    check("outs", {3'b0, got}, {3'b0, exp_q.pop_front()});
    check("s_and_r", {7'b0, s & r}, 8'h00);
    check("ctl_cover", {7'b0, (s | r) & ~control}, 8'h00);
    if (control && s) q_lat = 1'b1;
    else if (control && r) q_lat = 1'b0;
    cnt_s    += int'(s);
    cnt_r    += int'(r);
    cnt_busy += int'(busy);
    cnt_conf += int'(conflict);
    if (s) last_s = e;
    if (r && first_r < 0) first_r = e;
  endtask

  task automatic run(input int n, input logic sv, input logic rv);
    for (int i = 0; i < n; i++) drive(sv, rv, 1'b1);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int e0, s_edge, len;
    logic sv, rv, rn;

    // 1: reset held with requests toggling
    clear_counts();
    for (int i = 0; i < 8; i++) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    check("t1_reset", {4'b0, s, r, control, busy}, 8'h00);
    check("t1_busy_cnt", 8'(cnt_busy), 8'd0);
    run(10, 1'b0, 1'b0);

    // 2: long set request
    clear_counts();
    e0 = e + 1;
    s_edge = -1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'b1);
      if (s && s_edge < 0) s_edge = e;
    end
    run(30, 1'b0, 1'b0);
    check("t2_latency", 8'(s_edge - e0 + 1), 8'(DEB + 3));
    check("t2_s_cycles", 8'(cnt_s), 8'(PUL));
    check("t2_busy_cycles", 8'(cnt_busy), 8'(PUL + GAP_C));
    check("t2_q", {7'b0, q_lat}, 8'h01);

    // 3: short glitch on rst_req
    clear_counts();
    run(3, 1'b0, 1'b1);
    run(30, 1'b0, 1'b0);
    check("t3_r_cycles", 8'(cnt_r), 8'd0);
    check("t3_busy_cycles", 8'(cnt_busy), 8'd0);
    check("t3_s_cycles", 8'(cnt_s), 8'd0);

    // 4: both requests rise together
    clear_counts();
    run(20, 1'b1, 1'b1);
    run(30, 1'b0, 1'b0);
    check("t4_conflict", 8'(cnt_conf), 8'd1);
    check("t4_s_cycles", 8'(cnt_s), 8'd0);
    check("t4_r_cycles", 8'(cnt_r), 8'(PUL));
    check("t4_q", {7'b0, q_lat}, 8'h00);

    // 5: set accepted, then reset accepted during the set pulse
    run(10, 1'b0, 1'b0);
    clear_counts();
    run(2, 1'b1, 1'b0);
    run(18, 1'b1, 1'b1);
    run(40, 1'b0, 1'b0);
    check("t5_s_cycles", 8'(cnt_s), 8'(PUL));
    check("t5_r_cycles", 8'(cnt_r), 8'(PUL));
    check("t5_conflict", 8'(cnt_conf), 8'd0);
    check("t5_spacing", 8'(first_r - last_s), 8'(GAP_C + 2));
    check("t5_q", {7'b0, q_lat}, 8'h00);

    // 6: reset dropped in the 3rd cycle of a set pulse
    clear_counts();
    s_edge = -1;
    for (int i = 0; i < 20 && s_edge < 0; i++) begin
      drive(1'b1, 1'b0, 1'b1);
      if (s) s_edge = e;
    end
    check("t6_wait", {7'b0, s_edge >= 0}, 8'h01);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    clear_counts();
    run(30, 1'b0, 1'b0);
    check("t6_no_residual_s", 8'(cnt_s), 8'd0);
    check("t6_no_residual_busy", 8'(cnt_busy), 8'd0);

    // 7: random request bursts with occasional resets
    for (int seg = 0; seg < 200; seg++) begin
      len = $urandom_range(1, 12);
      sv  = 1'($urandom_range(0, 1));
      rv  = 1'($urandom_range(0, 1));
      rn  = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      if (!rn) len = 2;
      for (int i = 0; i < len; i++) drive(sv, rv, rn);
    end
    run(30, 1'b0, 1'b0);
    check("exp_q_drained", 8'(exp_q.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
